double_word_sequencer: RTL and testbench

- Word-bus initiator that performs one atomic double-word read or write against a double-word register window on the word-wide peripheral bus.
- The window exposes a low-word strobe pair (read_lo/load_lo) and a high-word strobe pair (read_hi/load_hi).
- A requester (DMA helper or a wide-operand unit) hands this block one DW-bit request. The block issues the low word, then the high word on the very next cycle, as the window's one-cycle holding register requires.
- When the access completes, the block returns the assembled DW-bit read data with a done pulse.

---
 rtl/double_word_sequencer_if.sv | 43 ++++
 rtl/double_word_sequencer.sv | 113 +++++++++++
 tb/tb_double_word_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/double_word_sequencer_if.sv
// rtl/double_word_sequencer_if.sv - request and word-bus signal bundle for double_word_sequencer
//
// Purpose: groups the requester handshake and the word-bus window signals.
// Ports (signals):
//   req_valid, req_write, req_data[DW]  request from requester
//   req_ready                           sequencer can accept a request
//   bus_grant, bus_data_in[WW]          word bus grant and window read data
//   bus_data_out[WW]                    window write data
//   read_lo, read_hi, load_lo, load_hi  window strobes
//   rd_double[DW], done, busy           result and status
// Modports: slave = the sequencer, master = requester/bus environment.
interface double_word_sequencer_if #(
   parameter int WW = 16
) ();
   localparam int DW = WW * 2;

   logic          req_valid;
   logic          req_write;
   logic [DW-1:0] req_data;
   logic          req_ready;
   logic          bus_grant;
   logic [WW-1:0] bus_data_in;
   logic [WW-1:0] bus_data_out;
   logic          read_lo;
   logic          read_hi;
   logic          load_lo;
   logic          load_hi;
   logic [DW-1:0] rd_double;
   logic          done;
   logic          busy;

   modport slave (
      input  req_valid, req_write, req_data, bus_grant, bus_data_in,
      output req_ready, bus_data_out, read_lo, read_hi, load_lo, load_hi,
             rd_double, done, busy
   );

   modport master (
      output req_valid, req_write, req_data, bus_grant, bus_data_in,
      input  req_ready, bus_data_out, read_lo, read_hi, load_lo, load_hi,
             rd_double, done, busy
   );
endinterface

// File: rtl/double_word_sequencer.sv
// rtl/double_word_sequencer.sv - atomic double-word read/write over a word-wide register window
//
// Purpose: accepts one DW-bit request, waits for the word bus grant, then
// accesses the low word and the high word on two consecutive cycles and
// reports completion with a one-cycle done pulse.
// Ports:
//   sysclk    system clock, rising edge
//   sysreset  asynchronous active-high reset
//   bus       double_word_sequencer_if.slave (request handshake, window strobes,
//             window data, assembled read result, done/busy status)
module double_word_sequencer #(
   parameter int WW = 16
) (
   input logic                   sysclk,
   input logic                   sysreset,
   double_word_sequencer_if.slave bus
);
   localparam int MSB  = WW - 1;
   localparam int DW   = WW * 2;
   localparam int DMSB = DW - 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ARB  = 3'd1,
      S_LO   = 3'd2,
      S_HI   = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic          write_q, write_d;
   logic [DMSB:0] data_q, data_d;
   logic [MSB:0]  res_lo_q, res_lo_d;
   logic [DMSB:0] rd_double_q, rd_double_d;

   // State register
   always_ff @(posedge sysclk or posedge sysreset) begin
      if (sysreset) begin
         state_q     <= S_IDLE;
         write_q     <= 1'b0;
         data_q      <= '0;
         res_lo_q    <= '0;
         rd_double_q <= '0;
      end else begin
         state_q     <= state_d;
         write_q     <= write_d;
         data_q      <= data_d;
         res_lo_q    <= res_lo_d;
         rd_double_q <= rd_double_d;
      end
   end

   // Next-state and datapath capture
   always_comb begin
      state_d     = state_q;
      write_d     = write_q;
      data_d      = data_q;
      res_lo_d    = res_lo_q;
      rd_double_d = rd_double_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               write_d = bus.req_write;
               data_d  = bus.req_data;
               state_d = S_ARB;
            end
         end
         S_ARB: begin
            if (bus.bus_grant) begin
               state_d = S_LO;
            end
         end
         S_LO: begin
            if (!write_q) begin
               res_lo_d = bus.bus_data_in;
            end
            state_d = S_HI;
         end
         S_HI: begin
            // The whole result is published at once so rd_double never shows
            // a half-updated value; writes leave the previous result in place.
            if (!write_q) begin
               rd_double_d = {bus.bus_data_in, res_lo_q};
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs decoded from registered state only, so strobes cannot glitch
   always_comb begin
      bus.req_ready    = (state_q == S_IDLE);
      bus.busy         = (state_q != S_IDLE);
      bus.done         = (state_q == S_DONE);
      bus.read_lo      = (state_q == S_LO) && !write_q;
      bus.read_hi      = (state_q == S_HI) && !write_q;
      bus.load_lo      = (state_q == S_LO) &&  write_q;
      bus.load_hi      = (state_q == S_HI) &&  write_q;
      bus.rd_double    = rd_double_q;
      bus.bus_data_out = '0;
      if (bus.load_lo) begin
         bus.bus_data_out = data_q[MSB:0];
      end else if (bus.load_hi) begin
         bus.bus_data_out = data_q[DMSB:WW];
      end
   end
endmodule

// File: tb/tb_double_word_sequencer.sv
// tb/tb_double_word_sequencer.sv - scoreboard testbench for double_word_sequencer
module tb_double_word_sequencer;
   localparam int WW    = 16;
   localparam int DW    = 32;
   localparam int LIMIT = 200;

   logic sysclk   = 1'b0;
   logic sysreset = 1'b1;
   always #5 sysclk = ~sysclk;

   double_word_sequencer_if #(.WW(WW)) bus ();
   double_word_sequencer #(.WW(WW)) dut (
      .sysclk  (sysclk),
      .sysreset(sysreset),
      .bus     (bus)
   );

   int tests = 0;
   int fails = 0;

   typedef struct {
      bit            w;
      logic [DW-1:0] d;
      logic [DW-1:0] exp_rd;
   } txn_t;
   txn_t sb[$];

   // Reference model: window contents and last read result as whole double words
   logic [DW-1:0] model_win;
   logic [DW-1:0] model_rd;

   // Environment: word window storage and grant control
   logic [WW-1:0] win_lo, win_hi;
   logic          env_set;
   logic [DW-1:0] env_val;
   bit            rand_grant;
   bit            grant_force;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   always @(posedge sysclk) begin
      if (env_set) begin
         {win_hi, win_lo} <= env_val;
      end else begin
         if (bus.load_lo) win_lo <= bus.bus_data_out;
         if (bus.load_hi) win_hi <= bus.bus_data_out;
      end
   end

   assign bus.bus_data_in = bus.read_lo ? win_lo : (bus.read_hi ? win_hi : '0);

   always @(posedge sysclk) begin
      #2;
      bus.bus_grant = rand_grant ? ($urandom_range(0, 1) == 1) : grant_force;
   end

   // Monitor: strobe rules, write data capture, done checks, then accept/push
   int            prev;
   int            n_lo, n_hi;
   logic [WW-1:0] lo_word, hi_word;

   always @(negedge sysclk) begin
      int nstb;
      txn_t t;
      if (sysreset) begin
         sb.delete();
         model_rd = '0;
         prev = 0; n_lo = 0; n_hi = 0;
      end else begin
         if (env_set) model_win = env_val;
         nstb = int'(bus.read_lo) + int'(bus.read_hi) + int'(bus.load_lo) + int'(bus.load_hi);
         if (nstb != 0) begin
            check("one_strobe", nstb, 1);
            check("strobe_in_txn", sb.size() != 0, 1);
            if (sb.size() != 0) check("strobe_kind", bus.load_lo | bus.load_hi, sb[0].w);
         end
         if (!bus.load_lo && !bus.load_hi) check("dout_zero", bus.bus_data_out, 0);
         if (bus.busy) check("ready_low_busy", bus.req_ready, 0);
         if (bus.read_hi) check("rd_hi_after_lo", prev, 1);
         if (bus.load_hi) check("ld_hi_after_lo", prev, 2);
         if (prev == 1) check("rd_lo_then_hi", bus.read_hi, 1);
         if (prev == 2) check("ld_lo_then_hi", bus.load_hi, 1);
         if (bus.read_lo || bus.load_lo) begin n_lo++; lo_word = bus.bus_data_out; end
         if (bus.read_hi || bus.load_hi) begin n_hi++; hi_word = bus.bus_data_out; end
         prev = bus.read_lo ? 1 : (bus.load_lo ? 2 : 0);
         if (bus.done) begin
            check("done_with_txn", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               t = sb.pop_front();
               check("n_lo", n_lo, 1);
               check("n_hi", n_hi, 1);
               if (t.w) begin
                  check("wr_lo_word", lo_word, t.d[WW-1:0]);
                  check("wr_hi_word", hi_word, t.d[DW-1:WW]);
               end
               check("rd_double", bus.rd_double, t.exp_rd);
            end
            n_lo = 0; n_hi = 0;
         end
         if (bus.req_valid && bus.req_ready) begin
            check("accept_idle", sb.size(), 0);
            t.w = bus.req_write;
            t.d = bus.req_data;
            if (t.w) begin
               model_win = t.d;
            end else begin
               model_rd = model_win;
            end
            t.exp_rd = model_rd;
            sb.push_back(t);
         end
      end
   end

   task automatic set_env(input logic [DW-1:0] v);
      @(posedge sysclk); #1;
      env_set = 1'b1; env_val = v;
      @(posedge sysclk); #1;
      env_set = 1'b0;
   endtask

   task automatic issue(input bit w, input logic [DW-1:0] d);
      int n = 0;
      @(posedge sysclk); #1;
      bus.req_valid = 1'b1; bus.req_write = w; bus.req_data = d;
      @(negedge sysclk);
      while (!bus.req_ready && n < LIMIT) begin
         @(negedge sysclk); n++;
      end
      check("accept_bound", n < LIMIT, 1);
      @(posedge sysclk); #1;
      bus.req_valid = 1'b0; bus.req_write = 1'($urandom); bus.req_data = DW'($urandom);
   endtask

   task automatic wait_done(output int n, output int first_strobe);
      n = 0; first_strobe = 0;
      do begin
         @(negedge sysclk); n++;
         if (first_strobe == 0 && (bus.read_lo || bus.load_lo)) first_strobe = n;
      end while (!bus.done && n < LIMIT);
      check("done_bound", n < LIMIT, 1);
   endtask

   initial begin
      int n, fs;
      logic [DW-1:0] v;
      rand_grant = 0; grant_force = 1;
      env_set = 0; env_val = '0;
      model_win = '0; model_rd = '0;
      bus.req_valid = 0; bus.req_write = 0; bus.req_data = '0;
      repeat (3) @(posedge sysclk);
      @(negedge sysclk);
      check("rst_ready", bus.req_ready, 1);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_strobes", {bus.read_lo, bus.read_hi, bus.load_lo, bus.load_hi}, 0);
      check("rst_dout", bus.bus_data_out, 0);
      check("rst_rd_double", bus.rd_double, 0);
      @(posedge sysclk); #1 sysreset = 0;

      // Write 0xDEADBEEF with grant high
      issue(1, 32'hDEADBEEF);
      wait_done(n, fs);
      check("wr_latency", n, 4);
      check("wr_lo_cycle", fs, 2);

      // Read 0xABCD1234 from the window
      set_env(32'hABCD1234);
      issue(0, 32'h0);
      wait_done(n, fs);
      check("rd_latency", n, 4);
      check("rd_value", bus.rd_double, 32'hABCD1234);

      // Grant low for 3 cycles after accept, dropped again after LO begins
      set_env(32'h5A5AC3C3);
      @(posedge sysclk); #1 grant_force = 0;
      issue(0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge sysclk);
         check("arb_busy", bus.busy, 1);
         check("arb_no_strobe", {bus.read_lo, bus.read_hi, bus.load_lo, bus.load_hi}, 0);
      end
      @(posedge sysclk); #1 grant_force = 1;
      @(negedge sysclk);
      check("arb_grant_edge", {bus.read_lo, bus.read_hi, bus.load_lo, bus.load_hi}, 0);
      @(posedge sysclk); #1 grant_force = 0;
      @(negedge sysclk);
      check("lo_after_grant", bus.read_lo, 1);
      @(negedge sysclk);
      check("hi_grant_low", bus.read_hi, 1);
      wait_done(n, fs);
      grant_force = 1;

      // Back-to-back with req_valid held high: write then read
      @(posedge sysclk); #1;
      bus.req_valid = 1; bus.req_write = 1; bus.req_data = 32'h00010002;
      n = 0;
      @(negedge sysclk);
      while (!bus.req_ready && n < LIMIT) begin @(negedge sysclk); n++; end
      @(posedge sysclk); #1;
      bus.req_write = 0; bus.req_data = DW'($urandom);
      n = 0;
      do begin @(negedge sysclk); n++; end while (!bus.req_ready && n < LIMIT);
      check("b2b_spacing", n, 5);
      @(posedge sysclk); #1 bus.req_valid = 0;
      wait_done(n, fs);
      check("b2b_read", bus.rd_double, 32'h00010002);

      // Async reset in the LO cycle of a write
      issue(1, 32'hCAFEF00D);
      n = 0;
      do begin @(negedge sysclk); n++; end while (!bus.load_lo && n < LIMIT);
      check("lo_seen_bound", n < LIMIT, 1);
      #2 sysreset = 1;
      #1;
      check("rst_lo_drop", bus.load_lo, 0);
      check("rst_lo_busy", bus.busy, 0);
      check("rst_lo_ready", bus.req_ready, 1);
      repeat (2) @(posedge sysclk);
      #1 sysreset = 0;
      set_env(32'h13572468);
      repeat (4) @(negedge sysclk);
      issue(0, 32'h0);
      wait_done(n, fs);
      check("post_rst_read", bus.rd_double, 32'h13572468);

      // Random requests with random grant
      rand_grant = 1;
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            v = DW'($urandom);
            set_env(v);
         end
         issue(1'($urandom), DW'($urandom));
         wait_done(n, fs);
         repeat ($urandom_range(0, 2)) @(posedge sysclk);
      end
      rand_grant = 0;
      repeat (5) @(negedge sysclk);
      check("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
